// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port SRAM between fetch and data ports.
// ARB_STARVE_GUARD_EN adds the fetch starvation guard.
module riscv_mem_arbiter #(
  parameter int AWIDTH   = 12,
  parameter int DWIDTH   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              I_REQ,
  input  logic [AWIDTH-1:0] I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [DWIDTH-1:0] I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WEN,
  input  logic [3:0]        D_BE,
  input  logic [AWIDTH-1:0] D_ADDR,
  input  logic [DWIDTH-1:0] D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [DWIDTH-1:0] D_RDATA,
  output logic              M_CSN,
  output logic              M_WEN,
  output logic [3:0]        M_BE,
  output logic [AWIDTH-1:0] M_ADDR,
  output logic [DWIDTH-1:0] M_DOUT,
  input  logic [DWIDTH-1:0] M_DIN,
  output logic [31:0]       I_WAIT_CNT,
  output logic [31:0]       D_WAIT_CNT
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_DR
  } own_e;

  own_e        own_q, own_d;
  logic        i_win, d_win, force_i;
  logic [31:0] iw_q, iw_d;
  logic [31:0] dw_q, dw_d;

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("MAX_WAIT must be in 1..15");
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] MaxW = 4'(MAX_WAIT);

  logic [3:0] starve_q, starve_d;

  assign force_i = I_REQ && (starve_q == MaxW);

  always_comb begin
    starve_d = '0;
    if (I_REQ && !i_win) begin
      starve_d = (starve_q == MaxW) ? starve_q
                                    : starve_q + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign force_i = 1'b0;
`endif

  // Grants are held off while reset is asserted.
  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (RSTn) begin
      if (force_i)    i_win = 1'b1;
      else if (D_REQ) d_win = 1'b1;
      else if (I_REQ) i_win = 1'b1;
    end
  end

  assign I_GNT = i_win;
  assign D_GNT = d_win;

  always_comb begin
    M_CSN  = 1'b1;
    M_WEN  = 1'b1;
    M_BE   = 4'b0000;
    M_ADDR = '0;
    M_DOUT = '0;
    own_d  = OWN_NONE;
    unique case (1'b1)
      i_win: begin
        M_CSN  = 1'b0;
        M_ADDR = I_ADDR;
        own_d  = OWN_I;
      end
      d_win: begin
        M_CSN  = 1'b0;
        M_WEN  = D_WEN;
        M_BE   = D_BE;
        M_ADDR = D_ADDR;
        M_DOUT = D_WDATA;
        own_d  = D_WEN ? OWN_DR : OWN_NONE;
      end
      default: ;
    endcase
  end

  always_comb begin
    iw_d = iw_q;
    dw_d = dw_q;
    if (I_REQ && !i_win && iw_q != '1)
      iw_d = iw_q + 32'd1;
    if (D_REQ && !d_win && dw_q != '1)
      dw_d = dw_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      own_q <= OWN_NONE;
      iw_q  <= '0;
      dw_q  <= '0;
    end else begin
      own_q <= own_d;
      iw_q  <= iw_d;
      dw_q  <= dw_d;
    end
  end

  assign I_RVALID   = (own_q == OWN_I);
  assign D_RVALID   = (own_q == OWN_DR);
  assign I_RDATA    = I_RVALID ? M_DIN : '0;
  assign D_RDATA    = D_RVALID ? M_DIN : '0;
  assign I_WAIT_CNT = iw_q;
  assign D_WAIT_CNT = dw_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter.
// Directed cases plus random traffic against a reference model.
module tb_riscv_mem_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int MAXW = 3;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          CLK;
  logic          rstn;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          d_req, d_wen;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;

  logic          I_GNT, I_RVALID, D_GNT, D_RVALID;
  logic [DW-1:0] I_RDATA, D_RDATA;
  logic          M_CSN, M_WEN;
  logic [3:0]    M_BE;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_DOUT, M_DIN;
  logic [31:0]   I_WAIT_CNT, D_WAIT_CNT;

  riscv_mem_arbiter #(
    .AWIDTH(AW), .DWIDTH(DW), .MAX_WAIT(MAXW)
  ) dut (
    .CLK(CLK), .RSTn(rstn),
    .I_REQ(i_req), .I_ADDR(i_addr),
    .I_GNT(I_GNT), .I_RVALID(I_RVALID),
    .I_RDATA(I_RDATA),
    .D_REQ(d_req), .D_WEN(d_wen), .D_BE(d_be),
    .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_GNT(D_GNT), .D_RVALID(D_RVALID),
    .D_RDATA(D_RDATA),
    .M_CSN(M_CSN), .M_WEN(M_WEN), .M_BE(M_BE),
    .M_ADDR(M_ADDR), .M_DOUT(M_DOUT), .M_DIN(M_DIN),
    .I_WAIT_CNT(I_WAIT_CNT), .D_WAIT_CNT(D_WAIT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM with registered DOUT and byte-enabled writes.
  logic [DW-1:0] sram [4096] = '{default: '0};
  always @(posedge CLK) begin
    if (!M_CSN) begin
      if (!M_WEN) begin
        for (int b = 0; b < 4; b++)
          if (M_BE[b]) sram[M_ADDR][8*b +: 8] <= M_DOUT[8*b +: 8];
      end else begin
        M_DIN <= sram[M_ADDR];
      end
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [4096] = '{default: '0};
  int            m_own;
  int            m_starve;
  logic [DW-1:0] m_rd;
  logic [31:0]   m_iw, m_dw;
  int            last_w;
  int            n_cmp, n_err;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs already driven after negedge.
  task automatic cyc(input bit drop_rst);
    int w;
    #1;
    w = 0;
    if (rstn) begin
      if (GUARD && m_starve == MAXW && i_req) w = 1;
      else if (d_req)                         w = 2;
      else if (i_req)                         w = 1;
    end
    check("i_gnt",  32'(I_GNT), 32'(w == 1));
    check("d_gnt",  32'(D_GNT), 32'(w == 2));
    check("m_csn",  32'(M_CSN), 32'(w == 0));
    check("m_wen",  32'(M_WEN), (w == 2) ? 32'(d_wen) : 32'd1);
    check("m_be",   32'(M_BE),  (w == 2) ? 32'(d_be) : 32'd0);
    check("m_addr", 32'(M_ADDR),
          (w == 1) ? 32'(i_addr) : (w == 2) ? 32'(d_addr) : 32'd0);
    if (w != 1)
      check("m_dout", M_DOUT, (w == 2) ? d_wdata : 32'd0);
    check("i_rvalid", 32'(I_RVALID), 32'(m_own == 1));
    check("d_rvalid", 32'(D_RVALID), 32'(m_own == 2));
    check("i_rdata", I_RDATA, (m_own == 1) ? m_rd : 32'd0);
    check("d_rdata", D_RDATA, (m_own == 2) ? m_rd : 32'd0);
    check("i_wait", I_WAIT_CNT, m_iw);
    check("d_wait", D_WAIT_CNT, m_dw);
    last_w = w;
    if (drop_rst) rstn = 1'b0;
    @(posedge CLK);
    if (!rstn) begin
      m_own = 0; m_starve = 0; m_iw = '0; m_dw = '0;
    end else begin
      if (i_req && w != 1 && m_iw != '1) m_iw = m_iw + 1;
      if (d_req && w != 2 && m_dw != '1) m_dw = m_dw + 1;
      if (i_req && w != 1)
        m_starve = (m_starve + 1 > MAXW) ? MAXW : m_starve + 1;
      else
        m_starve = 0;
      m_own = 0;
      if (w == 1) begin
        m_own = 1; m_rd = ref_mem[i_addr];
      end else if (w == 2 && d_wen) begin
        m_own = 2; m_rd = ref_mem[d_addr];
      end else if (w == 2) begin
        for (int b = 0; b < 4; b++)
          if (d_be[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
      end
    end
    @(negedge CLK);
  endtask

  task automatic dwr(input logic [AW-1:0] a,
                     input logic [DW-1:0] v,
                     input logic [3:0] be);
    d_req = 1; d_wen = 0; d_addr = a; d_wdata = v; d_be = be;
    cyc(0);
    d_req = 0;
  endtask

  task automatic drd(input logic [AW-1:0] a);
    d_req = 1; d_wen = 1; d_addr = a; d_be = 0; d_wdata = 0;
    cyc(0);
    d_req = 0;
  endtask

  task automatic do_reset();
    i_req = 0; d_req = 0; rstn = 0;
    cyc(0);
    cyc(0);
    rstn = 1;
  endtask

  initial begin
    int ng;
    n_cmp = 0; n_err = 0;
    m_own = 0; m_starve = 0; m_rd = '0;
    m_iw = '0; m_dw = '0; last_w = 0;
    rstn = 0; i_req = 0; i_addr = 0;
    d_req = 0; d_wen = 1; d_be = 0; d_addr = 0; d_wdata = 0;
    @(negedge CLK);
    cyc(0);
    i_req = 1; i_addr = 12'h010;
    cyc(0);
    check("rst_i_wait", I_WAIT_CNT, 32'd0);
    check("rst_m_csn", 32'(M_CSN), 32'd1);
    i_req = 0; rstn = 1;

    dwr(12'h010, 32'h00500093, 4'hF);
    dwr(12'h200, 32'h0000001E, 4'hF);
    dwr(12'h100, 32'hFFFFFFFF, 4'hF);

    // fetch only
    i_req = 1; i_addr = 12'h010;
    cyc(0);
    i_req = 0;
    check("fetch_rvalid", 32'(I_RVALID), 32'd1);
    check("fetch_rdata", I_RDATA, 32'h00500093);
    check("fetch_d_rvalid", 32'(D_RVALID), 32'd0);

    // conflict
    i_req = 1; i_addr = 12'h010;
    d_req = 1; d_wen = 1; d_addr = 12'h200;
    cyc(0);
    d_req = 0;
    check("conf_d_rdata", D_RDATA, 32'h0000001E);
    #1 check("conf_i_gnt", 32'(I_GNT), 32'd1);
    cyc(0);
    i_req = 0;
    check("conf_i_wait", I_WAIT_CNT, 32'd1);

    // partial write
    dwr(12'h100, 32'hDEADBEEF, 4'b0011);
    check("pw_no_rvalid", 32'(D_RVALID), 32'd0);
    drd(12'h100);
    check("pw_rdata", D_RDATA, 32'hFFFFBEEF);

    // starvation
    do_reset();
    i_req = 1; i_addr = 12'h004;
    d_req = 1; d_wen = 1; d_addr = 12'h008;
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 3; k++) cyc(0);
    check("starve_i_wait", I_WAIT_CNT, 32'd3);
    #1 check("starve_force", 32'(I_GNT), 32'd1);
    cyc(0);
    #1 check("starve_d_next", 32'(D_GNT), 32'd1);
    cyc(0);
`else
    ng = 0;
    for (int k = 0; k < 20; k++) begin
      #1 if (I_GNT) ng++;
      cyc(0);
    end
    check("strict_no_ignt", 32'(ng), 32'd0);
    check("strict_i_wait", I_WAIT_CNT, 32'd20);
`endif
    i_req = 0; d_req = 0;
    cyc(0);

    // reset during read
    d_req = 1; d_wen = 1; d_addr = 12'h200;
    cyc(1);
    check("rst_rd_rvalid", 32'(D_RVALID), 32'd0);
    check("rst_rd_iw", I_WAIT_CNT, 32'd0);
    check("rst_rd_dw", D_WAIT_CNT, 32'd0);
    check("rst_rd_csn", 32'(M_CSN), 32'd1);
    cyc(0);
    d_req = 0; rstn = 1;

    // streaming fetch
    for (int k = 0; k < 8; k++)
      dwr(12'(k), 32'hA5000000 + 32'(k), 4'hF);
    for (int k = 0; k < 8; k++) begin
      i_req = 1; i_addr = 12'(k);
      cyc(0);
      check("stream_rvalid", 32'(I_RVALID), 32'd1);
      check("stream_rdata", I_RDATA, 32'hA5000000 + 32'(k));
    end
    i_req = 0;
    check("stream_i_wait", I_WAIT_CNT, 32'd0);
    cyc(0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (!(i_req && last_w != 1 && $urandom_range(0, 9) != 0)) begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = 12'($urandom_range(0, 31));
      end
      if (!(d_req && last_w != 2 && $urandom_range(0, 9) != 0)) begin
        d_req   = ($urandom_range(0, 2) == 0);
        d_wen   = 1'($urandom_range(0, 1));
        d_be    = 4'($urandom_range(0, 15));
        d_addr  = 12'($urandom_range(0, 31));
        d_wdata = $urandom;
      end
      rstn = ($urandom_range(0, 99) != 0);
      cyc(0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
